// File: rtl/par2ser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : par2ser_pkg
// Description : Shared types and constants for the par2ser_shifter block.
// Revision    : 1.0 - initial release
// ============================================================================
package par2ser_pkg;

  // Frame sequencer states; PARITY is reachable only when PAR2SER_PARITY_EN
  // is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Default word width.
  localparam int C_DEFAULT_SIZE = 4;

endpackage : par2ser_pkg
`default_nettype wire

// File: rtl/shift_reg_lsb.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_lsb
// Description : SIZE-bit parallel-load, right-shifting register. q0 exposes
//               the current LSB so the bit can be sent before the shift.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_lsb #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            shift,
  input  logic [SIZE-1:0] d,
  output logic            q0
);

  logic [SIZE-1:0] r_shreg;

  // Load takes priority; a shift moves towards the LSB and back-fills zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg <= '0;
    end else if (load) begin
      r_shreg <= d;
    end else if (shift) begin
      r_shreg <= {1'b0, r_shreg[SIZE-1:1]};
    end
  end

  assign q0 = r_shreg[0];

endmodule : shift_reg_lsb
`default_nettype wire

// File: rtl/par2ser_shifter.sv
`default_nettype none
// ============================================================================
// Module      : par2ser_shifter
// Description : Parallel-to-serial read-out stage. Accepts a SIZE-bit word
//               over valid/ready and emits it LSB first, one bit per ena
//               strobe. Optional feature macro PAR2SER_PARITY_EN appends an
//               even-parity bit to every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module par2ser_shifter
  import par2ser_pkg::*;
#(
  parameter int SIZE  = C_DEFAULT_SIZE,
  parameter int CNT_W = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] d,
  output logic            sout,
  output logic            sout_valid,
  output logic            last
);

  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(SIZE - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_load;
  logic             w_shift;
  logic             w_q0;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_last;

  assign w_cnt_last = (r_cnt == C_LAST_CNT);
  assign in_ready   = (r_state == IDLE);

  shift_reg_lsb #(
    .SIZE (SIZE)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .shift (w_shift),
    .d     (d),
    .q0    (w_q0)
  );

`ifdef PAR2SER_PARITY_EN
  logic r_par;

  // Capture the word's even parity at accept time; d is not held afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_load) begin
      r_par <= ^d;
    end
  end
`endif

  // Frame sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state plus load/shift strobes; accept ignores ena, bits need ena.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_load       = 1'b1;
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (ena) begin
          w_shift = 1'b1;
          if (w_cnt_last) begin
`ifdef PAR2SER_PARITY_EN
            w_next_state = PARITY;
`else
            w_next_state = IDLE;
`endif
          end
        end
      end
`ifdef PAR2SER_PARITY_EN
      PARITY: begin
        if (ena) begin
          w_next_state = IDLE;
        end
      end
`endif
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Bit counter: cleared on accept, advanced with every emitted data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_shift) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Serial outputs move only on ena edges; an idle ena slot clears them,
  // which gives the guaranteed gap between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      last       <= 1'b0;
    end else if (ena) begin
      case (r_state)
        SHIFT: begin
          sout       <= w_q0;
          sout_valid <= 1'b1;
`ifdef PAR2SER_PARITY_EN
          last       <= 1'b0;
`else
          last       <= w_cnt_last;
`endif
        end
`ifdef PAR2SER_PARITY_EN
        PARITY: begin
          sout       <= r_par;
          sout_valid <= 1'b1;
          last       <= 1'b1;
        end
`endif
        default: begin
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          last       <= 1'b0;
        end
      endcase
    end
  end

endmodule : par2ser_shifter
`default_nettype wire

// File: tb/tb_par2ser_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_par2ser_shifter
// Description : Directed self-checking bench for par2ser_shifter (SIZE=4).
//               Expected serial bits are hand-written tables: bit k of each
//               table is the k-th serial bit, bit 4 is the parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_par2ser_shifter;

  localparam int SIZE = 4;
`ifdef PAR2SER_PARITY_EN
  localparam int FL = SIZE + 1;
`else
  localparam int FL = SIZE;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            ena;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] d;
  logic            sout;
  logic            sout_valid;
  logic            last;

  int passed = 0;
  int total  = 0;

  par2ser_shifter #(
    .SIZE (SIZE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .d          (d),
    .sout       (sout),
    .sout_valid (sout_valid),
    .last       (last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a word with ena=1 and check the whole frame plus the gap slot.
  task automatic frame(input string tag, input logic [SIZE-1:0] w, input logic [4:0] exp_bits);
    ena = 1'b1; in_valid = 1'b1; d = w;
    tick();
    in_valid = 1'b0; d = ~w;
    check({tag, "_ready_low"}, in_ready, 0);
    check({tag, "_accept_no_valid"}, sout_valid, 0);
    for (int k = 0; k < FL; k++) begin
      tick();
      check($sformatf("%s_bit%0d", tag, k), sout, exp_bits[k]);
      check($sformatf("%s_valid%0d", tag, k), sout_valid, 1);
      check($sformatf("%s_last%0d", tag, k), last, (k == FL - 1) ? 1 : 0);
    end
    check({tag, "_ready_end"}, in_ready, 1);
    tick();
    check({tag, "_gap_valid"}, sout_valid, 0);
    check({tag, "_gap_last"}, last, 0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1; ena = 1'b0; in_valid = 1'b0; d = '0;
    tick(); tick();
    check("rst_sout", sout, 0);
    check("rst_valid", sout_valid, 0);
    check("rst_last", last, 0);
    rst = 1'b0;
    #1;
    check("rst_ready", in_ready, 1);

    // ---------------- basic frames ----------------
    frame("basic_1011", 4'b1011, 5'b1_1011);
    frame("basic_0011", 4'b0011, 5'b0_0011);

    // ---------------- strobed rate: ena every 3rd cycle ----------------
    ena = 1'b0; in_valid = 1'b1; d = 4'b0110;
    tick();
    in_valid = 1'b0; d = 4'b1111;
    for (int c = 0; c <= 3 * FL; c++) begin
      int n;
      ena = (c % 3 == 0);
      tick();
      n = c / 3 + 1;
      if (n <= FL) begin
        logic [4:0] tb3;
        tb3 = 5'b0_0110;
        check($sformatf("strobe_bit_c%0d", c), sout, tb3[n-1]);
        check($sformatf("strobe_valid_c%0d", c), sout_valid, 1);
        check($sformatf("strobe_last_c%0d", c), last, (n == FL) ? 1 : 0);
      end else begin
        check($sformatf("strobe_gap_c%0d", c), sout_valid, 0);
      end
    end
    check("strobe_ready", in_ready, 1);

    // ---------------- back-to-back with in_valid held ----------------
    ena = 1'b1; in_valid = 1'b1; d = 4'b1111;
    tick();
    d = 4'b0000;
    check("b2b_ready_low", in_ready, 0);
    for (int k = 0; k < FL; k++) begin
      logic [4:0] ta;
      ta = 5'b0_1111;
      tick();
      check($sformatf("b2b_a_bit%0d", k), sout, ta[k]);
      check($sformatf("b2b_a_valid%0d", k), sout_valid, 1);
      if (k < FL - 1) check($sformatf("b2b_a_busy%0d", k), in_ready, 0);
    end
    tick();
    check("b2b_gap_valid", sout_valid, 0);
    check("b2b_b_accepted", in_ready, 0);
    in_valid = 1'b0; d = 4'b1111;
    for (int k = 0; k < FL; k++) begin
      tick();
      check($sformatf("b2b_b_bit%0d", k), sout, 0);
      check($sformatf("b2b_b_valid%0d", k), sout_valid, 1);
    end
    tick();
    check("b2b_end_valid", sout_valid, 0);

    // ---------------- accept while ena=0 ----------------
    ena = 1'b0; in_valid = 1'b1; d = 4'b1001;
    tick();
    in_valid = 1'b0; d = 4'b0110;
    check("ena0_captured", in_ready, 0);
    tick(); tick();
    check("ena0_hold_valid", sout_valid, 0);
    ena = 1'b1;
    for (int k = 0; k < FL; k++) begin
      logic [4:0] t5;
      t5 = 5'b0_1001;
      tick();
      check($sformatf("ena0_bit%0d", k), sout, t5[k]);
      check($sformatf("ena0_valid%0d", k), sout_valid, 1);
    end
    tick();
    check("ena0_gap", sout_valid, 0);

    // ---------------- reset mid-frame ----------------
    ena = 1'b1; in_valid = 1'b1; d = 4'b1011;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("midrst_pre_bit1", sout, 1);
    check("midrst_pre_valid", sout_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_sout", sout, 0);
    check("midrst_valid", sout_valid, 0);
    check("midrst_last", last, 0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_ready", in_ready, 1);
    for (int k = 0; k < FL; k++) begin
      tick();
      check($sformatf("midrst_no_resume%0d", k), sout_valid, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_par2ser_shifter
`default_nettype wire
